ram4_bank: RTL and testbench

//   Four-word register bank that consumes the 4-way demultiplexed load lines.
//   A single load plus a 2-bit address is decoded 4-way into per-word load enables
//   (address 00->word A, 01->B, 10->C, 11->D). Those enables drive WIDTH-bit registers.
//   The read port is a registered 4:1 select. This is the RAM building block between
//   the demux/mux gate layer and the larger RAM8/RAM64 banks.

---
 rtl/ram4_bank.sv | 78 +++++++
 tb/tb_ram4_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4_bank.sv
// ram4_bank: four-word register bank with a 4-way decoded write port and a
// registered 4:1 read port (one cycle read latency).
// Optional feature: define RAM4_WRITE_THROUGH_EN to forward write data to the
// read port when load=1 on an edge. The default build is read-first.
module ram4_bank #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       address,
    input  logic             load,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       loadSel,
    output logic [3:0]       written
);

    logic [WIDTH-1:0] r_word [4];
    logic [WIDTH-1:0] r_out;
    logic [3:0]       r_written;
    logic [3:0]       w_load_sel;
    logic [WIDTH-1:0] w_read_data;

    // Decode load/address into one-hot per-word load enables; stays live during reset.
    always_comb begin
        w_load_sel = 4'b0000;
        if (load) begin
            unique case (address)
                2'b00:   w_load_sel = 4'b0001;
                2'b01:   w_load_sel = 4'b0010;
                2'b10:   w_load_sel = 4'b0100;
                default: w_load_sel = 4'b1000;
            endcase
        end
    end

    // Select the value captured by the read register at the next edge.
    always_comb begin
        w_read_data = r_word[address];
`ifdef RAM4_WRITE_THROUGH_EN
        // A write always targets the addressed word, so load=1 means a collision.
        if (load) begin
            w_read_data = in;
        end
`endif
    end

    // Storage words and sticky written flags; only the enabled word is updated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_word[i] <= '0;
            end
            r_written <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load_sel[i]) begin
                    r_word[i]    <= in;
                    r_written[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read port: captures the addressed word every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
        end else begin
            r_out <= w_read_data;
        end
    end

    assign out     = r_out;
    assign loadSel = w_load_sel;
    assign written = r_written;

endmodule

// File: tb/tb_ram4_bank.sv
// Scoreboard bench for ram4_bank: a behavioural model predicts the read
// register for every edge, pushes the prediction to a queue, and each test
// pops and compares after the edge. Set RAM4_WRITE_THROUGH_EN to match the DUT build.
module tb_ram4_bank;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic [1:0]   addr;
    logic         load;
    logic [W-1:0] dout;
    logic [3:0]   load_sel;
    logic [3:0]   written;

    int total;
    int bad;

    logic [W-1:0] m_word [4];
    logic [3:0]   m_written;
    logic [W-1:0] exp_q [$];

    ram4_bank #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (din),
        .address (addr),
        .load    (load),
        .out     (dout),
        .loadSel (load_sel),
        .written (written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_word[i] = '0;
        m_written = 4'b0000;
    endtask

    // Predict the read register for the coming edge, update the model, then take the edge.
    task automatic step();
        logic [W-1:0] e;
        e = m_word[addr];
`ifdef RAM4_WRITE_THROUGH_EN
        if (load) e = din;
`endif
        if (load) begin
            m_word[addr]    = din;
            m_written[addr] = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        // Power-on reset, held across an edge.
        reset = 1'b1; load = 1'b0; addr = 2'b00; din = '0;
        model_clear();
        @(posedge clk); #1;
        total++;
        if (dout !== '0) begin bad++; $display("FAIL reset_out: got %h want 0000", dout); end
        total++;
        if (written !== 4'b0000) begin
            bad++; $display("FAIL reset_written: got %b want 0000", written);
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        // Write BEEF to A, then read it back so out is non-zero before the mid-run reset.
        load = 1'b1; addr = 2'b00; din = 16'hBEEF;
        step();
        e = exp_q.pop_front();
        load = 1'b0;
        step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e || e !== 16'hBEEF) begin
            bad++; $display("FAIL pre_reset_read: got %h want BEEF", dout);
        end
        // Asynchronous assert between edges.
        #2 reset = 1'b1;
        #1;
        total++;
        if (dout !== '0) begin bad++; $display("FAIL async_reset_out: got %h want 0000", dout); end
        total++;
        if (written !== 4'b0000) begin
            bad++; $display("FAIL async_reset_written: got %b want 0000", written);
        end
        model_clear();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        addr = 2'b00; load = 1'b0;
        step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e || e !== '0) begin
            bad++; $display("FAIL post_reset_read_a: got %h want %h", dout, e);
        end
    endtask

    task automatic test_decode();
        logic [3:0] want;
        load = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            want = 4'b0001 << a;
            #1;
            total++;
            if (load_sel !== want) begin
                bad++; $display("FAIL decode_load1_addr%0d: got %b want %b", a, load_sel, want);
            end
        end
        load = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            total++;
            if (load_sel !== 4'b0000) begin
                bad++; $display("FAIL decode_load0_addr%0d: got %b want 0000", a, load_sel);
            end
        end
    endtask

    task automatic test_write_read_all();
        logic [W-1:0] e;
        logic [W-1:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        load = 1'b1;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0]; din = vals[a];
            step();
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL write_%0d_out: got %h want %h", a, dout, e); end
        end
        load = 1'b0; din = 'x;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            step();
            e = exp_q.pop_front();
            total++;
            if (dout !== e || e !== vals[a]) begin
                bad++; $display("FAIL read_%0d: got %h want %h", a, dout, vals[a]);
            end
        end
        total++;
        if (written !== 4'b1111) begin bad++; $display("FAIL written_all: got %b want 1111", written); end
    endtask

    task automatic test_collision();
        logic [W-1:0] e;
        load = 1'b1; addr = 2'b01; din = 16'hABCD;
        step();
        e = exp_q.pop_front();
        total++;
`ifdef RAM4_WRITE_THROUGH_EN
        if (dout !== e || e !== 16'hABCD) begin
            bad++; $display("FAIL collision_edge: got %h want ABCD", dout);
        end
`else
        if (dout !== e || e !== 16'h2222) begin
            bad++; $display("FAIL collision_edge: got %h want 2222", dout);
        end
`endif
        load = 1'b0; din = 'x;
        step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e || e !== 16'hABCD) begin
            bad++; $display("FAIL collision_next: got %h want ABCD", dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        load = 1'b1; addr = 2'b00;
        din = 16'hAAAA; step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e) begin bad++; $display("FAIL b2b_first: got %h want %h", dout, e); end
        din = 16'h5555; step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e) begin bad++; $display("FAIL b2b_second: got %h want %h", dout, e); end
        load = 1'b0; din = 'x; step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e || e !== 16'h5555) begin
            bad++; $display("FAIL b2b_last_wins: got %h want 5555", dout);
        end
    endtask

    task automatic test_isolation();
        logic [W-1:0] e;
        load = 1'b1;
        addr = 2'b10; din = 16'h00FF; step(); e = exp_q.pop_front();
        addr = 2'b11; din = 16'hFF00; step(); e = exp_q.pop_front();
        load = 1'b0; din = 'x;
        // Address changes every cycle; out lags by one edge.
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            step();
            e = exp_q.pop_front();
            total++;
            if (dout !== e) begin bad++; $display("FAIL isolation_read_%0d: got %h want %h", a, dout, e); end
        end
        total++;
        if (m_word[2] !== 16'h00FF || written[3:2] !== 2'b11) begin
            bad++; $display("FAIL isolation_written: got %b want 11", written[3:2]);
        end
        total++;
        if (written !== m_written) begin
            bad++; $display("FAIL written_sticky: got %b want %b", written, m_written);
        end
    endtask

    task automatic test_reset_during_write();
        logic [W-1:0] e;
        load = 1'b1; addr = 2'b10; din = 16'h5A5A;
        reset = 1'b1;
        model_clear();
        @(posedge clk); #2;
        reset = 1'b0;
        load = 1'b0; din = 'x;
        @(posedge clk); #1;
        total++;
        if (written[2] !== 1'b0) begin
            bad++; $display("FAIL reset_write_flag: got %b want 0", written[2]);
        end
        step();
        e = exp_q.pop_front();
        total++;
        if (dout !== e || e !== '0) begin
            bad++; $display("FAIL reset_write_read_c: got %h want 0000", dout);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_decode();
        test_write_read_all();
        test_collision();
        test_back_to_back();
        test_isolation();
        test_reset_during_write();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
